// File: rtl/keypad_alu_if.sv
// Handshake and readout bundle between the keypad/command sources and keypad_alu_core.
// The master side drives keys, commands and the display read address; the slave side drives ready, result and flags.
interface keypad_alu_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);

  logic             key_valid;
  logic [3:0]       key_code;
  logic [AW-1:0]    key_dst;
  logic             key_ready;
  logic             cmd_valid;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_a;
  logic [AW-1:0]    cmd_b;
  logic [AW-1:0]    cmd_d;
  logic             cmd_ready;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             carry;
  logic             zero;
  logic             busy;

  modport master (
    output key_valid, key_code, key_dst, cmd_valid, cmd_op, cmd_a, cmd_b, cmd_d, rd_addr,
    input  key_ready, cmd_ready, rd_data, res_valid, res_data, carry, zero, busy
  );

  modport slave (
    input  key_valid, key_code, key_dst, cmd_valid, cmd_op, cmd_a, cmd_b, cmd_d, rd_addr,
    output key_ready, cmd_ready, rd_data, res_valid, res_data, carry, zero, busy
  );
endinterface

// File: rtl/keypad_alu_core.sv
// Register file loaded digit-by-digit from a hex keypad, plus a handshaked register-to-register ALU.
// Define KALU_MUL_EN to make opcode 111 an unsigned multiply; otherwise it passes operand A through.
//
//   state  | meaning
//   S_IDLE | accepting commands (priority) or keypad digits
//   S_EXEC | ALU evaluates latched operands into result/flag registers
//   S_WB   | result pulse; result written to destination register
module keypad_alu_core #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic         clk,
  input  logic         reset,
  keypad_alu_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d, zero_q, zero_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH:0]   sum, diff;
`ifdef KALU_MUL_EN
  logic [2*WIDTH-1:0] prod;
`endif

  always_comb begin
    sum  = {1'b0, opa_q} + {1'b0, opb_q};
    // The extra top bit of the widened difference is the unsigned borrow.
    diff = {1'b0, opa_q} - {1'b0, opb_q};
`ifdef KALU_MUL_EN
    prod = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};
`endif
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      3'b000: {alu_carry, alu_res} = sum;
      3'b001: {alu_carry, alu_res} = diff;
      3'b010: alu_res = opa_q & opb_q;
      3'b011: alu_res = opa_q | opb_q;
      3'b100: alu_res = opa_q ^ opb_q;
      3'b101: begin
        alu_res   = opa_q << 1;
        alu_carry = opa_q[WIDTH-1];
      end
      3'b110: begin
        alu_res   = opa_q >> 1;
        alu_carry = opa_q[0];
      end
      default: begin
`ifdef KALU_MUL_EN
        alu_res   = prod[WIDTH-1:0];
        alu_carry = |prod[2*WIDTH-1:WIDTH];
`else
        alu_res   = opa_q;
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    op_d    = op_q;
    dst_d   = dst_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          dst_d   = bus.cmd_d;
          opa_d   = regs_q[bus.cmd_a];
          opb_d   = regs_q[bus.cmd_b];
          state_d = S_EXEC;
        end else if (bus.key_valid) begin
          // Shift one hex digit in from the right; the top digit falls off.
          regs_d[bus.key_dst] = (regs_q[bus.key_dst] << 4) | WIDTH'(bus.key_code);
        end
      end
      S_EXEC: begin
        res_d   = alu_res;
        carry_d = alu_carry;
        zero_d  = (alu_res == '0);
        state_d = S_WB;
      end
      S_WB: begin
        regs_d[dst_q] = res_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      op_q    <= '0;
      dst_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.key_ready = (state_q == S_IDLE) & ~bus.cmd_valid;
  assign bus.busy      = (state_q != S_IDLE);
  // A reset landing in WB suppresses the pulse along with the write.
  assign bus.res_valid = (state_q == S_WB) & ~reset;
  assign bus.res_data  = res_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.rd_data   = regs_q[bus.rd_addr];
endmodule

// File: tb/tb_keypad_alu_core.sv
// Self-checking bench for keypad_alu_core (WIDTH=8, NREGS=4): cycle model plus directed literal checks.
// Honours KALU_MUL_EN for the opcode 111 expectations.
module tb_keypad_alu_core;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keypad_alu_if #(.WIDTH(8), .NREGS(4)) bus ();
  keypad_alu_core #(.WIDTH(8), .NREGS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register array, held result/flags, and cycles remaining in a command.
  logic [7:0] m_regs [4];
  logic [7:0] m_res;
  logic       m_carry, m_zero;
  int         m_cnt;
  logic [8:0] p_cr;
  int         p_d;

  function automatic logic [8:0] model_alu(input int op, input int a, input int b);
    int v;
    bit c;
    v = 0;
    c = 1'b0;
    case (op)
      0: begin v = a + b; c = (v > 255); end
      1: begin v = a - b; c = (a < b); end
      2: v = a & b;
      3: v = a | b;
      4: v = a ^ b;
      5: begin v = a * 2; c = (a >= 128); end
      6: begin v = a / 2; c = (a % 2) != 0; end
      default: begin
`ifdef KALU_MUL_EN
        v = a * b; c = (v > 255);
`else
        v = a;
`endif
      end
    endcase
    return {c, v[7:0]};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_regs[i] <= 8'h00;
      m_res   <= 8'h00;
      m_carry <= 1'b0;
      m_zero  <= 1'b0;
      m_cnt   <= 0;
    end else if (m_cnt == 0) begin
      if (bus.cmd_valid) begin
        p_cr  <= model_alu(int'(bus.cmd_op), int'(m_regs[bus.cmd_a]), int'(m_regs[bus.cmd_b]));
        p_d   <= int'(bus.cmd_d);
        m_cnt <= 2;
      end else if (bus.key_valid) begin
        m_regs[bus.key_dst] <= {m_regs[bus.key_dst][3:0], bus.key_code};
      end
    end else if (m_cnt == 2) begin
      m_res   <= p_cr[7:0];
      m_carry <= p_cr[8];
      m_zero  <= (p_cr[7:0] == 8'h00);
      m_cnt   <= 1;
    end else begin
      m_regs[p_d] <= m_res;
      m_cnt       <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_cmd_ready", bus.cmd_ready, m_cnt == 0);
      check("m_key_ready", bus.key_ready, (m_cnt == 0) && !bus.cmd_valid);
      check("m_busy",      bus.busy,      m_cnt != 0);
      check("m_res_valid", bus.res_valid, (m_cnt == 1) && !reset);
      check("m_res_data",  bus.res_data,  m_res);
      check("m_carry",     bus.carry,     m_carry);
      check("m_zero",      bus.zero,      m_zero);
      check("m_rd_data",   bus.rd_data,   m_regs[bus.rd_addr]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input int dst, input int code);
    bit done = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_dst   = dst[1:0];
    bus.key_code  = code[3:0];
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = bus.key_ready;
      tick();
    end
    bus.key_valid = 1'b0;
    check("key_accept", done, 1);
  endtask

  task automatic send_cmd(input int op, input int a, input int b, input int d);
    bit done = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op[2:0];
    bus.cmd_a     = a[1:0];
    bus.cmd_b     = b[1:0];
    bus.cmd_d     = d[1:0];
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accept", done, 1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 10 && !idle; i++) begin
      @(negedge clk);
      idle = !bus.busy;
      tick();
    end
    check("idle_wait", idle, 1);
  endtask

  task automatic rd_check(input int addr, input int exp, input string name);
    bus.rd_addr = addr[1:0];
    @(negedge clk);
    check(name, bus.rd_data, exp);
    tick();
  endtask

  // Issue a command, then pin its result in the pulse cycle T+2; returns in T+3.
  task automatic run_cmd(input int op, input int a, input int b, input int d,
                         input int er, input int ec, input int ez, input string name);
    send_cmd(op, a, b, d);
    tick();
    @(negedge clk);
    check({name, "_rv"},  bus.res_valid, 1);
    check({name, "_res"}, bus.res_data, er);
    check({name, "_c"},   bus.carry, ec);
    check({name, "_z"},   bus.zero, ez);
    tick();
  endtask

  initial begin
    bit exp_rdy [4];
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b1;
    bus.key_valid = 1'b0; bus.key_code = '0; bus.key_dst = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_d = '0;
    bus.rd_addr = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    @(negedge clk);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_key_ready", bus.key_ready, 1);
    check("rst_busy", bus.busy, 0);
    tick();
    for (int a = 0; a < 4; a++) rd_check(a, 0, "rst_reg");

    send_key(1, 'h3);
    send_key(1, 'hC);
    rd_check(1, 'h3C, "r1_3c");
    send_key(1, 'h5);
    rd_check(1, 'hC5, "r1_c5");

    send_key(0, 'hF); send_key(0, 'h0);
    send_key(1, 'h2); send_key(1, 'h0);

    // ADD r0+r1 -> r2 with latency pinned cycle by cycle
    bus.rd_addr = 2'd2;
    send_cmd(0, 0, 1, 2);
    @(negedge clk);
    check("add_rv_t1", bus.res_valid, 0);
    tick();
    @(negedge clk);
    check("add_rv_t2", bus.res_valid, 1);
    check("add_res", bus.res_data, 'h10);
    check("add_c", bus.carry, 1);
    check("add_z", bus.zero, 0);
    check("add_r2_t2", bus.rd_data, 0);
    tick();
    @(negedge clk);
    check("add_r2_t3", bus.rd_data, 'h10);
    check("add_rdy_t3", bus.cmd_ready, 1);
    tick();

    run_cmd(1, 1, 0, 3, 'h30, 1, 0, "sub_10");
    rd_check(3, 'h30, "sub_r3");
    run_cmd(1, 0, 0, 0, 'h00, 0, 1, "sub_00");
    rd_check(0, 0, "sub_r0");
    send_key(3, 'h0); send_key(3, 'h1);
    run_cmd(6, 3, 3, 3, 'h00, 1, 1, "shr");

    // Command and key together: command wins, key goes in after WB
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.cmd_a = 2'd1; bus.cmd_b = 2'd2; bus.cmd_d = 2'd3;
    bus.key_valid = 1'b1; bus.key_dst = 2'd0; bus.key_code = 4'h7;
    @(negedge clk);
    check("both_key_rdy", bus.key_ready, 0);
    check("both_cmd_rdy", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    @(negedge clk); check("both_key_t1", bus.key_ready, 0); tick();
    @(negedge clk); check("both_key_t2", bus.key_ready, 0); tick();
    @(negedge clk); check("both_key_t3", bus.key_ready, 1); tick();
    bus.key_valid = 1'b0;
    rd_check(0, 'h07, "both_r0");
    rd_check(3, 'h00, "both_r3");

    // cmd_valid held through busy: next accept only at T+3
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd3; bus.cmd_a = 2'd0; bus.cmd_b = 2'd1; bus.cmd_d = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_cmd_rdy", bus.cmd_ready, exp_rdy[i]);
      tick();
    end
    bus.cmd_valid = 1'b0;
    wait_idle();
    rd_check(2, 'h27, "hold_r2");

    // Reset while in EXEC aborts the command
    send_cmd(0, 0, 1, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_rv_t1", bus.res_valid, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort_rv_t2", bus.res_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_res", bus.res_data, 0);
    tick();
    for (int a = 0; a < 4; a++) rd_check(a, 0, "abort_reg");

    send_key(0, 'h1); send_key(0, 'h0);
    send_key(1, 'h2); send_key(1, 'h0);
`ifdef KALU_MUL_EN
    run_cmd(7, 0, 1, 2, 'h00, 1, 1, "op7_mul");
    rd_check(2, 'h00, "op7_r2");
`else
    run_cmd(7, 0, 1, 2, 'h10, 0, 0, "op7_pass");
    rd_check(2, 'h10, "op7_r2");
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
